// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer: widths, FSM
// state encoding and the PC-source select used by the next-PC mux.
package fetch_sequencer_pkg;

    localparam int FS_AW = 7;   // PC / instruction-memory address width
    localparam int FS_IW = 8;   // instruction word width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEL_INC  = 2'd0,   // sequential: pc_q + 1
        SEL_BR   = 2'd1,   // live redirect from execute
        SEL_PEND = 2'd2    // redirect captured while a fetch was in flight
    } pc_sel_e;

endpackage

// File: rtl/fetch_sequencer_pc_next_sel.sv
// Next-PC source mux: sequential increment (wrapping at 2^AW), the live
// branch target, or the branch target latched during an outstanding fetch.
module fetch_sequencer_pc_next_sel
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = FS_AW
) (
    input  logic [AW-1:0] i_pc_q,
    input  logic [AW-1:0] i_br_target,
    input  logic [AW-1:0] i_br_tgt,
    input  logic [1:0]    i_sel,
    output logic [AW-1:0] o_pc_next
);

    logic [AW-1:0] w_pc_inc;

    // Increment naturally wraps the top address back to zero.
    assign w_pc_inc = i_pc_q + {{(AW-1){1'b0}}, 1'b1};

    // Select the next PC according to the requested source.
    always_comb begin
        o_pc_next = w_pc_inc;
        case (i_sel)
            SEL_INC:  o_pc_next = w_pc_inc;
            SEL_BR:   o_pc_next = i_br_target;
            SEL_PEND: o_pc_next = i_br_tgt;
            default:  o_pc_next = w_pc_inc;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller sitting in front of the PC register.
// Issues held requests to instruction memory, hands fetched words to decode
// over a valid/ready pair, and applies branch redirects. A redirect that
// arrives while a fetch is in flight is remembered and applied when the
// memory answers; the stale instruction is then dropped.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = FS_AW,
    parameter int IW = FS_IW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    input  logic          stall,
    input  logic          br_valid,
    input  logic [AW-1:0] br_target,
    input  logic [AW-1:0] pc_q,
    output logic [AW-1:0] pc_next,
    output logic          pc_we,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_ack,
    input  logic [IW-1:0] imem_data,
    output logic [IW-1:0] ir,
    output logic          ir_valid,
    input  logic          ir_ready
);

    fetch_state_e  r_state;
    fetch_state_e  w_state_nxt;
    logic [IW-1:0] r_ir;
    logic          r_ir_valid;
    logic          r_br_pend;
    logic [AW-1:0] r_br_tgt;
    logic          r_imem_req;

    logic          w_go;
    logic          w_pc_we;
    pc_sel_e       w_sel;
    logic          w_load_ir;
    logic          w_clr_valid;
    logic          w_set_pend;
    logic          w_clr_pend;

    assign w_go = run & ~stall;

    // Next-state and control decode; branch beats pending branch beats ack beats ready.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_we     = 1'b0;
        w_sel       = SEL_INC;
        w_load_ir   = 1'b0;
        w_clr_valid = 1'b0;
        w_set_pend  = 1'b0;
        w_clr_pend  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (br_valid) begin
                    w_pc_we     = 1'b1;
                    w_sel       = SEL_BR;
                    w_state_nxt = w_go ? ST_REQ : ST_IDLE;
                end else if (w_go) begin
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    if (br_valid || r_br_pend) begin
                        // Fetched word is on the wrong path: drop it, redirect.
                        w_pc_we     = 1'b1;
                        w_sel       = br_valid ? SEL_BR : SEL_PEND;
                        w_clr_pend  = 1'b1;
                        w_state_nxt = w_go ? ST_REQ : ST_IDLE;
                    end else begin
                        w_pc_we     = 1'b1;
                        w_sel       = SEL_INC;
                        w_load_ir   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else if (br_valid) begin
                    // Request stays stable; remember where to go afterwards.
                    w_set_pend  = 1'b1;
                    w_state_nxt = ST_REQ;
                end else begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_HOLD: begin
                if (br_valid) begin
                    // Flush the held word even if decode takes it this cycle.
                    w_pc_we     = 1'b1;
                    w_sel       = SEL_BR;
                    w_clr_valid = 1'b1;
                    w_state_nxt = w_go ? ST_REQ : ST_IDLE;
                end else if (ir_ready) begin
                    w_clr_valid = 1'b1;
                    w_state_nxt = w_go ? ST_REQ : ST_IDLE;
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next-PC mux.
    fetch_sequencer_pc_next_sel #(
        .AW (AW)
    ) u_pc_next_sel (
        .i_pc_q      (pc_q),
        .i_br_target (br_target),
        .i_br_tgt    (r_br_tgt),
        .i_sel       (w_sel),
        .o_pc_next   (pc_next)
    );

    // The PC register must never be written while reset is asserted.
    assign pc_we     = w_pc_we & ~rst;
    assign imem_addr = pc_q;
    assign imem_req  = r_imem_req;
    assign ir        = r_ir;
    assign ir_valid  = r_ir_valid;

    // FSM state and the registered memory request flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_imem_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_imem_req <= (w_state_nxt == ST_REQ);
        end
    end

    // Instruction register and its valid flag toward decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ir       <= {IW{1'b0}};
            r_ir_valid <= 1'b0;
        end else if (w_load_ir) begin
            r_ir       <= imem_data;
            r_ir_valid <= 1'b1;
        end else if (w_clr_valid) begin
            r_ir_valid <= 1'b0;
        end
    end

    // Branch redirect latched while a fetch is still outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_pend <= 1'b0;
            r_br_tgt  <= {AW{1'b0}};
        end else if (w_clr_pend) begin
            r_br_pend <= 1'b0;
        end else if (w_set_pend) begin
            r_br_pend <= 1'b1;
            r_br_tgt  <= br_target;
        end
    end

endmodule
